// File: rtl/keypad_scan_ctrl_pkg.sv
// Shared types for the keypad scan controller: debounce FSM states,
// per-frame scan results and the column drive reset pattern.
package keypad_scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PRESS_DB = 2'd1,
        HELD     = 2'd2,
        REL_DB   = 2'd3
    } kp_state_t;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_res_t;

    localparam logic [3:0] COL_RESET = 4'b1110;

endpackage

// File: rtl/keypad_scan_ctrl_if.sv
// Keypad pins plus the key outputs that feed the LED display path.
// master = the scan controller, slave = the keypad/display side.
interface keypad_scan_ctrl_if;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] key_code;
    logic       IsPressed;
    logic       key_valid;

    modport master (input row_in, output col_out, key_code, IsPressed, key_valid);
    modport slave  (output row_in, input col_out, key_code, IsPressed, key_valid);
endinterface

// File: rtl/keypad_col_scanner.sv
// Column scanner: synchronises the rows, drives one column low at a time for
// SCAN_DIV cycles, builds a 16-bit hit map per frame and classifies it.
module keypad_col_scanner
    import keypad_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 27000
) (
    input  logic       clk,
    input  logic       sys_rst_n,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic       frame_done,
    output frame_res_t frame_result,
    output logic [3:0] frame_code
);
    localparam int DW = $clog2(SCAN_DIV);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);

    logic [3:0]    row_s1, row_s2;
    logic [DW-1:0] dwell;
    logic [1:0]    col_idx;
    logic [15:0]   hit_map, hit_next;
    logic          sample;
    frame_res_t    res_c;
    logic [3:0]    code_c;

    assign sample = (dwell == DWELL_LAST);

    // Two-flop synchroniser; idle rows read as released (all high).
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            row_s1 <= 4'b1111;
            row_s2 <= 4'b1111;
        end else begin
            row_s1 <= row_in;
            row_s2 <= row_s1;
        end
    end

    // Merge this column's low rows into the map; classify the whole frame.
    always_comb begin
        hit_next = hit_map;
        for (int r = 0; r < 4; r++)
            if (!row_s2[r]) hit_next[{2'(r), col_idx}] = 1'b1;
        res_c  = FR_NONE;
        code_c = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (hit_next[i]) begin
                if (res_c == FR_NONE) begin
                    res_c  = FR_SINGLE;
                    code_c = 4'(i);
                end else begin
                    res_c = FR_MULTI;
                end
            end
        end
    end

    // Dwell counter, column rotation and frame-end result registers.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            dwell        <= '0;
            col_out      <= COL_RESET;
            col_idx      <= 2'd0;
            hit_map      <= '0;
            frame_done   <= 1'b0;
            frame_result <= FR_NONE;
            frame_code   <= 4'd0;
        end else begin
            frame_done <= 1'b0;
            if (sample) begin
                dwell   <= '0;
                col_out <= {col_out[2:0], col_out[3]};
                col_idx <= col_idx + 2'd1;
                if (col_idx == 2'd3) begin
                    hit_map      <= '0;
                    frame_done   <= 1'b1;
                    frame_result <= res_c;
                    frame_code   <= code_c;
                end else begin
                    hit_map <= hit_next;
                end
            end else begin
                dwell <= dwell + DW'(1);
            end
        end
    end

endmodule

// File: rtl/keypad_scan_ctrl.sv
// 4x4 keypad scan controller: frame-level debounce FSM, registered key
// outputs and optional auto-repeat (enable with KEYPAD_AUTOREPEAT_EN).
module keypad_scan_ctrl
    import keypad_scan_ctrl_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 27000,
    parameter int unsigned DEBOUNCE_SCANS = 4,
    parameter int unsigned REPEAT_DELAY   = 500,
    parameter int unsigned REPEAT_RATE    = 100
) (
    input logic                clk,
    input logic                sys_rst_n,
    keypad_scan_ctrl_if.master kp
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_DONE = CW'(DEBOUNCE_SCANS);

    if (SCAN_DIV < 4) begin : g_bad_div
        $error("SCAN_DIV must be >= 4");
    end
    if (DEBOUNCE_SCANS < 1) begin : g_bad_db
        $error("DEBOUNCE_SCANS must be >= 1");
    end
    if (REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_rep
        $error("REPEAT_DELAY and REPEAT_RATE must be >= 1");
    end

    logic       frame_done;
    frame_res_t frame_result;
    logic [3:0] frame_code;

    kp_state_t     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic [3:0]    cand_q, cand_d;
    logic          accept, release_k, rep_fire;
    logic [3:0]    key_code_q;
    logic          pressed_q, valid_q;

    keypad_col_scanner #(.SCAN_DIV(SCAN_DIV)) u_scan (
        .clk          (clk),
        .sys_rst_n    (sys_rst_n),
        .row_in       (kp.row_in),
        .col_out      (kp.col_out),
        .frame_done   (frame_done),
        .frame_result (frame_result),
        .frame_code   (frame_code)
    );

    // Debounce next-state: at most one transition per frame end.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cand_d    = cand_q;
        accept    = 1'b0;
        release_k = 1'b0;
        cnt_inc   = (cnt_q == CNT_DONE) ? cnt_q : cnt_q + CNT_ONE;
        if (frame_done) begin
            case (state_q)
                IDLE: if (frame_result == FR_SINGLE) begin
                    cand_d = frame_code;
                    if (CNT_ONE >= CNT_DONE) begin
                        state_d = HELD;
                        cnt_d   = '0;
                        accept  = 1'b1;
                    end else begin
                        state_d = PRESS_DB;
                        cnt_d   = CNT_ONE;
                    end
                end
                PRESS_DB: begin
                    if (frame_result == FR_SINGLE && frame_code == cand_q) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_d = HELD;
                            cnt_d   = '0;
                            accept  = 1'b1;
                        end
                    end else if (frame_result == FR_SINGLE) begin
                        cand_d = frame_code;
                        cnt_d  = CNT_ONE;
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                HELD: if (frame_result == FR_NONE) begin
                    if (CNT_ONE >= CNT_DONE) begin
                        state_d   = IDLE;
                        cnt_d     = '0;
                        release_k = 1'b1;
                    end else begin
                        state_d = REL_DB;
                        cnt_d   = CNT_ONE;
                    end
                end
                REL_DB: begin
                    if (frame_result == FR_NONE) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == CNT_DONE) begin
                            state_d   = IDLE;
                            cnt_d     = '0;
                            release_k = 1'b1;
                        end
                    end else begin
                        // Release glitch: back to held without a new key event.
                        state_d = HELD;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int unsigned REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int RW = $clog2(REP_MAX + 1);

    logic [RW-1:0] rep_cnt, rep_inc, rep_target;
    logic          rep_first;

    // First repeat waits REPEAT_DELAY frames, later ones REPEAT_RATE.
    always_comb begin
        rep_target = rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
        rep_inc    = rep_cnt + RW'(1);
        rep_fire   = frame_done && state_q == HELD && state_d == HELD && rep_inc >= rep_target;
    end

    // Frame counter runs only while staying in HELD; any entry restarts it.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (state_q != HELD || state_d != HELD) begin
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (frame_done) begin
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_inc;
            end
        end
    end
`else
    assign rep_fire = 1'b0;
`endif

    // State register and registered key outputs.
    always_ff @(posedge clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            cand_q     <= 4'd0;
            key_code_q <= 4'd0;
            pressed_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cand_q  <= cand_d;
            valid_q <= accept | rep_fire;
            if (accept) begin
                key_code_q <= cand_d;
                pressed_q  <= 1'b1;
            end else if (release_k) begin
                pressed_q <= 1'b0;
            end
        end
    end

    assign kp.key_code  = key_code_q;
    assign kp.IsPressed = pressed_q;
    assign kp.key_valid = valid_q;

endmodule
